// File: rtl/sram_like_arbiter_pkg.sv
// Shared constants and helpers for the SRAM-like arbiter.
// Round-robin arbitration is selected by defining SRAM_ARB_RR_EN; otherwise fixed priority.
package sram_like_arbiter_pkg;

    // Default bus widths of the core's SRAM-like ports
    localparam int unsigned BusAddrW = 32;
    localparam int unsigned BusDataW = 32;

    // SRAM-like transfer size encodings
    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10
    } size_e;

    // Channel ID width; never narrower than one bit
    function automatic int unsigned id_width(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // Occupancy counter width, able to hold the value DEPTH itself
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Read/write pointer width; never narrower than one bit
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// Synchronous FIFO holding the channel ID of each accepted, not-yet-answered transaction.
// Pushes while full and pops while empty are ignored.
module arb_id_fifo
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned CntW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer advance with explicit wrap, and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like arbiter with in-order response routing through a channel-ID FIFO.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority (channel 0 highest).
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int unsigned NCH         = 2,
    parameter int unsigned OUTSTANDING = 4,
    parameter int unsigned ADDR_W      = BusAddrW,
    parameter int unsigned DATA_W      = BusDataW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCH-1:0]             m_req,
    input  logic [NCH-1:0]             m_wr,
    input  logic [2*NCH-1:0]           m_size,
    input  logic [ADDR_W*NCH-1:0]      m_addr,
    input  logic [(DATA_W/8)*NCH-1:0]  m_wstrb,
    input  logic [DATA_W*NCH-1:0]      m_wdata,
    output logic [NCH-1:0]             m_addrok,
    output logic [NCH-1:0]             m_dataok,
    output logic [DATA_W-1:0]          m_rdata,
    output logic                       s_req,
    output logic                       s_wr,
    output logic [1:0]                 s_size,
    output logic [ADDR_W-1:0]          s_addr,
    output logic [DATA_W/8-1:0]        s_wstrb,
    output logic [DATA_W-1:0]          s_wdata,
    input  logic                       s_addrok,
    input  logic                       s_dataok,
    input  logic [DATA_W-1:0]          s_rdata
);

    localparam int unsigned IdW   = id_width(NCH);
    localparam int unsigned StrbW = DATA_W / 8;

    logic [IdW-1:0] arb_id;
    logic [IdW-1:0] grant;
    logic [IdW-1:0] head_id;
    logic [IdW-1:0] lock_id_q, lock_id_d;
    logic           lock_valid_q, lock_valid_d;
    logic           lock_hold;
    logic           fifo_full, fifo_empty;
    logic           handshake;
    logic           pop;

`ifdef SRAM_ARB_RR_EN
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    int unsigned    rr_idx;
    logic           rr_found;

    // Round-robin: first requesting channel at or after rr_ptr
    always_comb begin
        arb_id   = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < NCH; k++) begin
            rr_idx = int'(rr_ptr_q) + k;
            if (rr_idx >= NCH) begin
                rr_idx = rr_idx - NCH;
            end
            if (!rr_found && m_req[rr_idx]) begin
                arb_id   = IdW'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end

    // Pointer moves past the channel that just completed a handshake
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (handshake) begin
            rr_ptr_d = (grant == IdW'(NCH - 1)) ? '0 : grant + 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: lowest requesting index wins
    always_comb begin
        arb_id = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (m_req[k]) begin
                arb_id = IdW'(k);
            end
        end
    end
`endif

    // A lock only holds while its owner keeps requesting; a dropped request frees the slave port
    assign lock_hold = lock_valid_q & m_req[lock_id_q];
    assign grant     = lock_hold ? lock_id_q : arb_id;
    assign s_req     = (|m_req) & ~fifo_full & ~reset;
    assign handshake = s_req & s_addrok;
    assign pop       = s_dataok & ~fifo_empty & ~reset;
    assign m_rdata   = s_rdata;

    // Request field mux and per-channel handshake/response strobes
    always_comb begin
        s_wr     = 1'b0;
        s_size   = '0;
        s_addr   = '0;
        s_wstrb  = '0;
        s_wdata  = '0;
        m_addrok = '0;
        m_dataok = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant == IdW'(k)) begin
                s_wr        = m_wr[k];
                s_size      = m_size[2*k +: 2];
                s_addr      = m_addr[ADDR_W*k +: ADDR_W];
                s_wstrb     = m_wstrb[StrbW*k +: StrbW];
                s_wdata     = m_wdata[DATA_W*k +: DATA_W];
                m_addrok[k] = handshake;
            end
            if (head_id == IdW'(k)) begin
                m_dataok[k] = pop;
            end
        end
    end

    // Lock the grant while the slave stalls an issued request
    always_comb begin
        lock_valid_d = 1'b0;
        lock_id_d    = lock_id_q;
        if (s_req && !s_addrok) begin
            lock_valid_d = 1'b1;
            lock_id_d    = grant;
        end
    end

    // Lock register
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
        end
    end

    arb_id_fifo #(
        .WIDTH (IdW),
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (handshake),
        .push_data (grant),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_id)
    );

endmodule
